// File: rtl/l1_cache_pkg.sv
// Shared sizing constants and controller state encoding for the L1 SRAM controller.
package l1_cache_pkg;

   localparam int ADDR_WIDTH   = 8;
   localparam int DATA_WIDTH   = 1024;
   localparam int NUM_WMASKS   = 128;
   localparam int RAM_DEPTH    = 1 << ADDR_WIDTH;
   localparam int STARVE_LIMIT = 3;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/l1_wr_arb.sv
// Refill-over-store write arbiter; a store waiting behind STARVE_LIMIT refill wins is forced through.
module l1_wr_arb
   import l1_cache_pkg::*;
#(
   parameter int STARVE_LIMIT = l1_cache_pkg::STARVE_LIMIT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic rf_valid_i,
   input  logic st_valid_i,
   output logic rf_gnt_o,
   output logic st_gnt_o
);

   localparam int            CW    = $clog2(STARVE_LIMIT + 2);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_q, starve_d;
   logic          st_win_s;

   always_comb begin
      st_win_s = st_valid_i && (!rf_valid_i || (starve_q == LIMIT));
      st_gnt_o = en_i && st_win_s;
      rf_gnt_o = en_i && rf_valid_i && !st_win_s;
      if (!st_valid_i || st_gnt_o) begin
         starve_d = {CW{1'b0}};
      end else if (rf_gnt_o) begin
         starve_d = starve_q + CW'(1);
      end else begin
         starve_d = starve_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q <= {CW{1'b0}};
      end else begin
         starve_q <= starve_d;
      end
   end

endmodule

// File: rtl/l1_sram_ctrl.sv
// L1 line-array controller: arbitrated write port, 1-cycle read port with response backpressure.
// Optional zero-fill sweep after reset / on flush_req when L1_SRAM_INIT_EN is defined.
module l1_sram_ctrl
   import l1_cache_pkg::*;
#(
   parameter int ADDR_WIDTH   = l1_cache_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH   = l1_cache_pkg::DATA_WIDTH,
   parameter int NUM_WMASKS   = l1_cache_pkg::NUM_WMASKS,
   parameter int STARVE_LIMIT = l1_cache_pkg::STARVE_LIMIT
) (
   input  logic                  clk,
   input  logic                  rst_n,
`ifdef L1_SRAM_INIT_EN
   input  logic                  flush_req,
`endif
   input  logic                  rf_valid,
   output logic                  rf_ready,
   input  logic [ADDR_WIDTH-1:0] rf_addr,
   input  logic [DATA_WIDTH-1:0] rf_data,
   input  logic                  st_valid,
   output logic                  st_ready,
   input  logic [ADDR_WIDTH-1:0] st_addr,
   input  logic [NUM_WMASKS-1:0] st_wmask,
   input  logic [DATA_WIDTH-1:0] st_data,
   input  logic                  rd_valid,
   output logic                  rd_ready,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  sram_csb0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   output logic                  sram_csb1,
   output logic [ADDR_WIDTH-1:0] sram_addr1,
   input  logic [DATA_WIDTH-1:0] sram_dout1,
   output logic                  init_done
);

   logic                  init_done_s, sweep_s, flush_s, run_s;
   logic                  rf_gnt_s, st_gnt_s, wr_any_s, rd_fire_s;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [ADDR_WIDTH-1:0] wr_addr_s, sweep_addr_s;

`ifdef L1_SRAM_INIT_EN
   localparam logic [ADDR_WIDTH-1:0] SWEEP_LAST = {ADDR_WIDTH{1'b1}};

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         sweep_q <= {ADDR_WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
      end
   end

   // A flush waits for the outstanding response to drain; new requests are held off meanwhile.
   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      case (state_q)
         ST_INIT: begin
            if (sweep_q == SWEEP_LAST) begin
               state_d = ST_RUN;
               sweep_d = {ADDR_WIDTH{1'b0}};
            end else begin
               sweep_d = sweep_q + ADDR_WIDTH'(1);
            end
         end
         ST_RUN: begin
            if (flush_req && !rsp_valid_q) begin
               state_d = ST_INIT;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_INIT;
            sweep_d = {ADDR_WIDTH{1'b0}};
         end
      endcase
   end

   assign init_done_s  = (state_q == ST_RUN);
   assign sweep_s      = rst_n && (state_q == ST_INIT);
   assign flush_s      = flush_req;
   assign sweep_addr_s = sweep_q;
`else
   assign init_done_s  = 1'b1;
   assign sweep_s      = 1'b0;
   assign flush_s      = 1'b0;
   assign sweep_addr_s = {ADDR_WIDTH{1'b0}};
`endif

   // rst_n gates the ports combinationally so the SRAM is deselected the instant reset asserts.
   assign run_s = rst_n && init_done_s && !flush_s;

   l1_wr_arb #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_wr_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (run_s),
      .rf_valid_i (rf_valid),
      .st_valid_i (st_valid),
      .rf_gnt_o   (rf_gnt_s),
      .st_gnt_o   (st_gnt_s)
   );

   assign wr_any_s  = rf_gnt_s || st_gnt_s;
   assign wr_addr_s = st_gnt_s ? st_addr : rf_addr;
   assign rf_ready  = rf_gnt_s;
   assign st_ready  = st_gnt_s;
   assign rd_ready  = run_s && (!rsp_valid_q || rsp_ready) && !(wr_any_s && (rd_addr == wr_addr_s));
   assign rd_fire_s = rd_valid && rd_ready;

   always_comb begin
      sram_csb0   = 1'b1;
      sram_addr0  = {ADDR_WIDTH{1'b0}};
      sram_wmask0 = {NUM_WMASKS{1'b0}};
      sram_din0   = {DATA_WIDTH{1'b0}};
      if (sweep_s) begin
         sram_csb0   = 1'b0;
         sram_addr0  = sweep_addr_s;
         sram_wmask0 = {NUM_WMASKS{1'b1}};
      end else if (rf_gnt_s) begin
         sram_csb0   = 1'b0;
         sram_addr0  = rf_addr;
         sram_wmask0 = {NUM_WMASKS{1'b1}};
         sram_din0   = rf_data;
      end else if (st_gnt_s) begin
         sram_csb0   = 1'b0;
         sram_addr0  = st_addr;
         sram_wmask0 = st_wmask;
         sram_din0   = st_data;
      end else begin
         sram_csb0   = 1'b1;
      end
   end

   assign sram_csb1  = !rd_fire_s;
   assign sram_addr1 = rd_addr;

   always_comb begin
      if (rd_fire_s) begin
         rsp_valid_d = 1'b1;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end else begin
         rsp_valid_d = rsp_valid_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // SRAM dout holds between reads, and no read issues while a response is stalled.
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = sram_dout1;
   assign init_done = init_done_s;

endmodule

// File: doc/l1_sram_ctrl.md
L1_SRAM_CTRL -- requirements
Module: l1_sram_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, 8, line index width; DATA_WIDTH, 1024, line bits; NUM_WMASKS, 128, byte lanes; STARVE_LIMIT, 3, max consecutive refill wins over a waiting store.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; ports: clk in 1 (all logic on posedge), rst_n in 1 (async active-low reset).
REQ-003 rf_valid in 1, rf_ready out 1, rf_addr in ADDR_WIDTH, rf_data in DATA_WIDTH: full-line refill write request.
REQ-004 st_valid in 1, st_ready out 1, st_addr in ADDR_WIDTH, st_wmask in NUM_WMASKS, st_data in DATA_WIDTH: byte-masked store write request.
REQ-005 rd_valid in 1, rd_ready out 1, rd_addr in ADDR_WIDTH: line read request.
REQ-006 rsp_valid out 1, rsp_ready in 1, rsp_data out DATA_WIDTH: read response.
REQ-007 sram_csb0 out 1, sram_addr0 out ADDR_WIDTH, sram_wmask0 out NUM_WMASKS, sram_din0 out DATA_WIDTH: write port, csb active-low.
REQ-008 sram_csb1 out 1, sram_addr1 out ADDR_WIDTH, sram_dout1 in DATA_WIDTH: read port; both SRAM clocks tied to clk externally.
REQ-009 init_done out 1: high when array usable; flush_req in 1: present only under L1_SRAM_INIT_EN.

Function
REQ-010 Handshake: transfer when valid&&ready at posedge; the winning write and accepted read drive SRAM ports combinationally in that cycle.
REQ-011 Write arbitration: refill beats store, except store SHALL win when starve_cnt==STARVE_LIMIT; starve_cnt increments on each refill grant while st_valid high, clears on store grant or st_valid low.
REQ-012 Refill grant: sram_wmask0 all ones, sram_din0=rf_data; store grant: sram_wmask0=st_wmask, sram_din0=st_data; no grant: sram_csb0=1.
REQ-013 At most one write per cycle; loser's ready SHALL be 0.
REQ-014 rd_ready SHALL be 0 when rd_addr equals the granted write address this cycle (collision stall); read issues the next cycle, returning post-write data.
REQ-015 rd_ready SHALL also require (!rsp_valid || rsp_ready).
REQ-016 Read latency exactly 1: rsp_valid rises the cycle after acceptance; rsp_data=sram_dout1, held stable because no new read issues until the response transfers.
REQ-017 rsp_valid clears on rsp_ready unless a new read is accepted in the same cycle (back-to-back, one per cycle).
REQ-018 All readies 0 and sram_csb1=1 while init_done=0.

Reset
REQ-019 During rst_n low: sram_csb0=1, sram_csb1=1, rsp_valid=0, all readies 0, starve_cnt=0, sweep counter=0; init_done=0 with macro, 1 without.
REQ-020 Reset asserted mid-sweep or mid-response SHALL abort it; the in-flight response is dropped.

Configuration
REQ-021 L1_SRAM_INIT_EN defined: FSM INIT/RUN; INIT entered after reset, writes zeros with wmask all ones to index 0..RAM_DEPTH-1, one per cycle, then RUN with init_done=1 (RAM_DEPTH cycles).
REQ-022 With macro, flush_req in RUN enters INIT once rsp_valid=0 and no grant pending; init_done drops the next cycle.
REQ-023 Without macro: no FSM, no flush_req port, init_done tied 1, array contents undefined after reset.

Structure
REQ-024 Shared package l1_cache_pkg SHALL hold ADDR_WIDTH, DATA_WIDTH, NUM_WMASKS, RAM_DEPTH and the INIT/RUN state enum.
REQ-025 Write arbiter with starvation counter SHALL be sub-module l1_wr_arb; remainder in l1_sram_ctrl.

Verification
REQ-026 Macro on: release reset -> 256 cycles of csb0=0, addr0 0..255, din0=0; init_done=1 on cycle 257; read 0x80 -> rsp_data=0.
REQ-027 rf_valid and st_valid held high 6 cycles -> grants R,R,R,S,R,R; starve_cnt resets after S.
REQ-028 Store addr 0x10, wmask=1, data byte 0xAB, with rd_addr 0x10 same cycle -> rd_ready=0, read next cycle, rsp_data[7:0]=0xAB, other bytes unchanged.
REQ-029 Reads 0x01,0x02 back-to-back, rsp_ready low 3 cycles after first rsp -> rd_ready=0, rsp_data stable for 3 cycles, second rsp follows one cycle after release.
REQ-030 rst_n low at sweep index 100 -> csb0=1 immediately; on release sweep restarts at 0.
REQ-031 Macro off: reset release -> init_done=1, rd_ready=1 in first cycle.
